// File: rtl/izh_pkg.sv
// Shared constants, FSM state type and the 2.16 fixed-point multiply used by
// the Izhikevich population scheduler.
package izh_pkg;

    localparam int N    = 18;
    localparam int FRAC = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_STALL,
        ST_DONE
    } state_e;

    localparam logic signed [N-1:0] FX_1P4  = 18'sh1_6666;
    localparam logic signed [N-1:0] FX_0P5  = 18'sh0_8000;
    localparam logic signed [N-1:0] FX_0P3  = 18'sh0_4CCD;
    localparam logic signed [N-1:0] FX_M0P5 = 18'sh3_8000;
    localparam logic signed [N-1:0] FX_M0P7 = 18'sh3_4CCD;
    localparam logic signed [N-1:0] FX_M0P2 = 18'sh3_CCCD;

    // Keeps the product's sign bit and drops the two redundant integer bits.
    function automatic logic signed [N-1:0] fx_mult(input logic signed [N-1:0] x,
                                                   input logic signed [N-1:0] y);
        logic signed [2*N-1:0] p;
        p = x * y;
        return {p[2*N-1], p[FRAC+N-2:FRAC]};
    endfunction

endpackage

// File: rtl/izh_neuron_update.sv
// Combinational Izhikevich step for one neuron: threshold test, spike reset
// and the shift-based v/u integration.
module izh_neuron_update #(
    parameter int N = 18
) (
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] u,
    input  logic signed [N-1:0] i,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] c14,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    input  logic        [3:0]   a_shift,
    input  logic        [3:0]   b_shift,
    output logic signed [N-1:0] v_nxt,
    output logic signed [N-1:0] u_nxt,
    output logic                spike
);
    import izh_pkg::*;

    logic signed [N-1:0] vv, acc, v_new, du, u_new;

    always_comb begin
        vv    = fx_mult(v, v);
        acc   = vv + v + (v >>> 2) + (c14 >>> 2) - (u >>> 2) + (i >>> 2);
        v_new = v + (acc >>> 2);
        du    = (v >>> b_shift) - u;
        u_new = u + ((du >>> a_shift) >>> 4);
        spike = v > v_th;
        v_nxt = spike ? c : v_new;
        u_nxt = spike ? u + d : u_new;
    end

endmodule

// File: rtl/izh_population_scheduler.sv
// Sweeps a neuron population through one shared update datapath and emits
// spike IDs on a single-entry valid/ready register. IZH_SPIKE_COUNT_EN adds spike_count.
module izh_population_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int N           = 18,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                init,
    input  logic signed [N-1:0] v_init,
    input  logic signed [N-1:0] u_init,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] c14,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    input  logic        [3:0]   a_shift,
    input  logic        [3:0]   b_shift,
    input  logic                cfg_we,
    input  logic [ID_W-1:0]     cfg_addr,
    input  logic signed [N-1:0] cfg_i,
    input  logic [ID_W-1:0]     rd_addr,
    output logic signed [N-1:0] rd_v,
    output logic signed [N-1:0] rd_u,
    output logic                busy,
    output logic                done,
    output logic                spike_valid,
    output logic [ID_W-1:0]     spike_id,
    input  logic                spike_ready
`ifdef IZH_SPIKE_COUNT_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);
    import izh_pkg::*;

    logic [NUM_NEURONS-1:0][N-1:0] v_q, v_d, u_q, u_d, i_q, i_d;
    state_e            state_q, state_d;
    logic [ID_W-1:0]   idx_q, idx_d, spike_id_q, spike_id_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              spike_valid_q, spike_valid_d;
    logic signed [N-1:0] cur_v, cur_u, cur_i, nxt_v, nxt_u;
    logic              nxt_spike, accept, post_ok;

`ifdef IZH_SPIKE_COUNT_EN
    localparam int CNT_W = $clog2(NUM_NEURONS+1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign spike_count = cnt_q;
`endif

    assign cur_v = v_q[idx_q];
    assign cur_u = u_q[idx_q];
    assign cur_i = i_q[idx_q];

    izh_neuron_update #(.N(N)) u_upd (
        .v(cur_v), .u(cur_u), .i(cur_i), .v_th(v_th), .c14(c14), .c(c), .d(d),
        .a_shift(a_shift), .b_shift(b_shift),
        .v_nxt(nxt_v), .u_nxt(nxt_u), .spike(nxt_spike)
    );

    assign rd_v        = v_q[rd_addr];
    assign rd_u        = u_q[rd_addr];
    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_valid = spike_valid_q;
    assign spike_id    = spike_id_q;

    assign accept  = spike_valid_q & spike_ready;
    assign post_ok = ~spike_valid_q | spike_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        v_d           = v_q;
        u_d           = u_q;
        i_d           = i_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        spike_valid_d = accept ? 1'b0 : spike_valid_q;
        spike_id_d    = spike_id_q;
`ifdef IZH_SPIKE_COUNT_EN
        cnt_d         = cnt_q;
`endif
        if (cfg_we) i_d[cfg_addr] = cfg_i;

        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    v_d = {NUM_NEURONS{v_init}};
                    u_d = {NUM_NEURONS{u_init}};
                end else if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef IZH_SPIKE_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_SWEEP: begin
                // A spike with nowhere to go freezes this neuron until the register drains.
                if (nxt_spike && !post_ok) begin
                    state_d = ST_STALL;
                end else begin
                    v_d[idx_q] = nxt_v;
                    u_d[idx_q] = nxt_u;
                    if (nxt_spike) begin
                        spike_valid_d = 1'b1;
                        spike_id_d    = idx_q;
`ifdef IZH_SPIKE_COUNT_EN
                        cnt_d         = cnt_q + CNT_W'(1);
`endif
                    end
                    if (idx_q == ID_W'(NUM_NEURONS-1)) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ID_W'(1);
                    end
                end
            end
            ST_STALL: if (spike_ready) state_d = ST_SWEEP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            v_q           <= '0;
            u_q           <= '0;
            i_q           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
`ifdef IZH_SPIKE_COUNT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            v_q           <= v_d;
            u_q           <= u_d;
            i_q           <= i_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
`ifdef IZH_SPIKE_COUNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/izh_population_scheduler.md
# izh_population_scheduler

Time-multiplexes one shared Izhikevich update datapath across a population of `NUM_NEURONS` neurons. Per-neuron state (v, u) and input current live in register arrays. On each `start` pulse the block sweeps every neuron once, one per cycle, and applies the spike/reset rule. Spikes leave as neuron-ID events on a valid/ready stream toward the routing fabric. The block sits between the network-level timestep controller and the spike router.

## Interface
- `NUM_NEURONS`, 16: population size, ≥2.
- `N`, 18: fixed-point width, signed 2.16.
- `ID_W`, $clog2(NUM_NEURONS): neuron index width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared.
- `start` in 1: begin one timestep sweep; honoured only in IDLE.
- `init` in 1: load every neuron with `v_init`/`u_init`; honoured only in IDLE.
- `v_init`, `u_init`, `v_th`, `c14`, `c`, `d` in N: global signed 2.16 parameters.
- `a_shift`, `b_shift` in 4: shift amounts that stand in for multipliers a and b.
- `cfg_we` in 1, `cfg_addr` in ID_W, `cfg_i` in N: write per-neuron input current.
- `rd_addr` in ID_W; `rd_v`, `rd_u` out N: combinational state readback.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep end.
- `spike_valid` out 1, `spike_id` out ID_W, `spike_ready` in 1: spike event stream.

## Operation
- FSM states: IDLE, SWEEP, STALL, DONE.
- IDLE
  - `init` → all v←`v_init`, u←`u_init` in one edge; stay in IDLE.
  - else `start` → SWEEP with idx=0.
  - `init` and `start` in the same cycle: `init` wins, `start` is dropped.
- SWEEP, neuron idx
  - If v > `v_th` (signed): v←`c`, u←u+`d`, post spike idx.
  - Else: v←v_new, u←u_new.
  - idx++ each cycle; after idx=NUM_NEURONS-1, go to DONE.
- Spike output is a single-entry register.
  - Neuron idx may post only if the register is empty, or is being accepted this cycle (`spike_valid`&`spike_ready`).
  - If neither holds, go to STALL. Neuron idx's state is not written and idx is held.
- STALL: return to SWEEP (re-evaluate idx) on the first cycle `spike_ready` is high.
- DONE: `done`=1 for one cycle, then IDLE. A pending spike may remain valid after `done`.
- `start`/`init` while busy are ignored.
- `cfg_we` is accepted in any state. A write to neuron k is used by any evaluation of k on a later edge. The write is lost if `reset` is asserted in the same cycle.
- Arithmetic (all wrap at N bits, `>>>` arithmetic):
  - mult(x,y) = {p[2N-1], p[2N-4:N-2]}, where p = x*y is 2N bits.
  - v_new = v + ((mult(v,v) + v + (v>>>2) + (c14>>>2) − (u>>>2) + (i>>>2)) >>> 2).
  - u_new = u + ((((v>>>b_shift) − u) >>> a_shift) >>> 4).
- Reset values: all v, u, i = 0; `busy`=0, `done`=0, `spike_valid`=0, `spike_id`=0; FSM=IDLE, idx=0.
- Reset mid-sweep aborts the sweep immediately; partially swept state is discarded (cleared).

## Timing
- `start` sampled at edge T: `busy`=1 from T. Neuron k is written at edge T+1+k when there are no stalls. `done` is high in the cycle after edge T+NUM_NEURONS, with `busy`=0 in that same cycle.
- Unstalled sweep: NUM_NEURONS+1 cycles from start edge to done.
- A spike from neuron k is visible on `spike_valid`/`spike_id` in the cycle after its write edge. It is held stable until accepted.
- Each stall cycle delays all later writes and `done` by one cycle.

## Configuration
- `IZH_SPIKE_COUNT_EN` defined:
  - Adds output `spike_count`, width $clog2(NUM_NEURONS+1).
  - Cleared on an accepted `start`; increments on each spike posted into the output register.
  - Held from `done` until the next `start`; reset value 0.
- Undefined: the port and its counter do not exist.

## Structure
- Package `izh_pkg` holds:
  - constants N=18, FRAC=16;
  - the FSM state enum;
  - the `fx_mult` function;
  - named 2.16 constants (e.g. 1.4 = 18'sh1_6666, −0.5 = 18'sh3_8000).
- Sub-module `izh_neuron_update`: purely combinational. Inputs v, u, i and the parameters; outputs next v, next u and a spike flag.
- The scheduler owns the arrays, the FSM, the output register and the counter.

## Test plan
- Reset mid-sweep: `start`, then assert `reset` at neuron 5 → all outputs 0, FSM IDLE, `rd_v`=`rd_u`=0 for every address.
- Forced spike: `init` with v_init=0.5 (18'sh0_8000), u_init=−0.2 (18'sh3_CCCD), v_th=0.3, c=−0.5, d=18'sh0_051E, then `start`, `spike_ready`=1 → IDs 0..15 in order on consecutive cycles. Every v=18'sh3_8000 and every u=u_init+d. `done` arrives 17 cycles after `start`.
- Subthreshold sweep: v_init=−0.7 (18'sh3_4CCD), u_init=−0.2, c14=1.4, i=0, a_shift=6, b_shift=2, 10 sweeps → no spikes. v/u match the bit-exact golden model each sweep.
- Backpressure: all neurons spike, `spike_ready` held 0 for 8 cycles after the first valid → neuron 1 stays unwritten (`rd_v` unchanged) and `busy` stays high. After release, the sweep completes with no lost or duplicated IDs and `done` is delayed by the stall length.
- Control collisions: `init`+`start` together in IDLE → init applied, no sweep. `start` while busy → ignored. A `cfg_we` to neuron 15 during the sweep at idx 3 → neuron 15 uses the new i in the same sweep.
- With `IZH_SPIKE_COUNT_EN`: a 16-spike sweep gives `spike_count`=16. The next `start` clears it to 0.
